pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, PC and target width in bits.
REQ-002 Parameter RESET_VEC, default 32'hBFC0_0000, PC value on reset.
REQ-003 Parameter EXC_VEC, default 32'h8000_0180, exception redirect target.
REQ-004 Parameter INC, default 4, sequential PC increment.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 stall  input  1  downstream stall; PC SHALL hold while high.
REQ-008 imem_ready  input  1  instruction memory accepts current pc this cycle.
REQ-009 exc_valid  input  1  exception redirect request, target EXC_VEC.
REQ-010 br_taken  input  1  taken-branch redirect request.
REQ-011 br_target  input  ADDR_W  branch target.
REQ-012 jmp_valid  input  1  jump redirect request.
REQ-013 jmp_target  input  ADDR_W  jump target.
REQ-014 pc  output  ADDR_W  registered fetch address.
REQ-015 pc_next_seq  output  ADDR_W  combinational pc + INC.
REQ-016 fetch_valid  output  1  pc is a valid fetch request.
REQ-017 redirect_pending  output  1  a redirect is latched awaiting advance.
REQ-018 misalign  output  1  registered; last loaded redirect target had nonzero bits [1:0].

Function
REQ-019 advance = imem_ready & ~stall; pc SHALL update only on an advance edge.
REQ-020 On advance, the next pc SHALL be selected with priority: live exc, pending exc, live branch, live jump, pending branch/jump, pc + INC.
REQ-021 When any redirect is live and advance is low, the target and its class SHALL be latched into the pending register on that edge; redirect_pending SHALL be 1 from the following cycle.
REQ-022 A later live redirect while pending SHALL overwrite the pending entry, except a pending exception, which only a live exception overwrites.
REQ-023 Simultaneous live requests SHALL be resolved by the REQ-020 order before latching; only one target is ever stored.
REQ-024 The pending entry SHALL be cleared on the advance edge that consumes it or that is overridden by a higher-priority live redirect.
REQ-025 Redirect targets SHALL be loaded with bits [1:0] forced to 0; misalign SHALL reflect the unforced target bits of that load, and clear on a sequential advance.
REQ-026 pc + INC SHALL wrap modulo 2^ADDR_W; e.g., 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 fetch_valid SHALL be 0 while redirect_pending is 1; otherwise 1 out of reset.
REQ-028 Redirect-to-pc latency SHALL be one edge when advance is high in the request cycle.

Reset
REQ-029 While rst_n is 0: pc = RESET_VEC, pending cleared, redirect_pending = 0, misalign = 0, fetch_valid = 0.
REQ-030 On the first rising edge after rst_n rises, fetch_valid SHALL be 1 and pc SHALL still be RESET_VEC.
REQ-031 Reset asserted mid-operation SHALL discard any pending redirect immediately.

Structure
REQ-032 Package pc_gen_pkg SHALL hold ADDR_W, RESET_VEC, EXC_VEC, INC defaults and the source-select encoding SEL_SEQ, SEL_EXC, SEL_BR, SEL_JMP, SEL_PEND.
REQ-033 Next-PC selection SHALL be a separate combinational sub-module pc_sel_mux (select encoding in, ADDR_W out); the pending register and the PC register stay in pc_gen.

Verification
REQ-034 Reset release, imem_ready=1, stall=0, 3 edges -> pc 32'hBFC0_0000, ..._0004, ..._0008, ..._000C.
REQ-035 br_taken=1, br_target=32'h0040_0100 with jmp_valid=1 in the same cycle, advance=1 -> next pc 32'h0040_0100, fetch_valid stays 1.
REQ-036 stall=1, jmp_target=32'h0040_0200 pulsed, then stall=0 two cycles later -> redirect_pending=1, fetch_valid=0 during stall; pc=32'h0040_0200 after release; pending cleared.
REQ-037 Pending exception, then live branch during stall -> pc=32'h8000_0180 on release; the branch is ignored.
REQ-038 pc=32'hFFFF_FFFC, advance -> pc=32'h0000_0000; br_target=32'h0040_0102 -> pc=32'h0040_0100, misalign=1.
REQ-039 rst_n low mid-stall with pending redirect -> pc=RESET_VEC, redirect_pending=0 asynchronously.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: default geometry and next-pc source encoding for pc_gen.
package pc_gen_pkg;
  localparam int ADDR_W = 32;
  localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;
  localparam int INC = 4;
  typedef enum logic [2:0] {SEL_SEQ, SEL_EXC, SEL_BR, SEL_JMP, SEL_PEND} sel_e;
endpackage

// File: rtl/pc_sel_mux.sv
// pc_sel_mux: picks the raw (unaligned) next-pc candidate for a given source select.
module pc_sel_mux import pc_gen_pkg::*; #(
  parameter int ADDR_W = pc_gen_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] EXC_VEC = pc_gen_pkg::EXC_VEC
) (
  input  sel_e              sel,
  input  logic [ADDR_W-1:0] seq,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic [ADDR_W-1:0] pend_target,
  output logic [ADDR_W-1:0] nxt
);
  always_comb
    nxt = sel == SEL_EXC  ? EXC_VEC :
          sel == SEL_BR   ? br_target :
          sel == SEL_JMP  ? jmp_target :
          sel == SEL_PEND ? pend_target : seq;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch pc register with prioritised redirects and a single-entry pending redirect.
module pc_gen import pc_gen_pkg::*; #(
  parameter int ADDR_W = pc_gen_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = pc_gen_pkg::RESET_VEC,
  parameter logic [ADDR_W-1:0] EXC_VEC = pc_gen_pkg::EXC_VEC,
  parameter int INC = pc_gen_pkg::INC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              exc_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              fetch_valid,
  output logic              redirect_pending,
  output logic              misalign
);
  logic              started, pend_exc, adv;
  logic [ADDR_W-1:0] pend_target, nxt;
  sel_e              sel;
  assign pc_next_seq = pc + ADDR_W'(INC);
  assign fetch_valid = started & ~redirect_pending;
  // the first edge out of reset only arms fetch; pc starts moving on the next one
  assign adv = imem_ready & ~stall & started;
  always_comb
    sel = exc_valid                       ? SEL_EXC :
          redirect_pending & pend_exc     ? SEL_PEND :
          br_taken                        ? SEL_BR :
          jmp_valid                       ? SEL_JMP :
          redirect_pending                ? SEL_PEND : SEL_SEQ;
  pc_sel_mux #(.ADDR_W(ADDR_W), .EXC_VEC(EXC_VEC)) u_mux (
    .sel(sel), .seq(pc_next_seq), .br_target(br_target), .jmp_target(jmp_target),
    .pend_target(pend_target), .nxt(nxt)
  );
  // a blocked live redirect is latched unless a pending exception shadows it (sel==SEL_PEND then)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_VEC;
      started <= 1'b0;
      redirect_pending <= 1'b0;
      pend_exc <= 1'b0;
      pend_target <= '0;
      misalign <= 1'b0;
    end else begin
      started <= 1'b1;
      if (adv) begin
        pc <= sel == SEL_SEQ ? nxt : {nxt[ADDR_W-1:2], 2'b00};
        misalign <= sel != SEL_SEQ && |nxt[1:0];
        redirect_pending <= 1'b0;
      end else if (sel inside {SEL_EXC, SEL_BR, SEL_JMP}) begin
        redirect_pending <= 1'b1;
        pend_exc <= sel == SEL_EXC;
        pend_target <= nxt;
      end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven directed sequences plus randomized run against a behavioural model.
module tb_pc_gen;
  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] EV = 32'h8000_0180;
  logic clk = 0, rst_n = 0, stall = 0, imem_ready = 0, exc_valid = 0, br_taken = 0, jmp_valid = 0;
  logic [31:0] br_target = 0, jmp_target = 0, pc, pc_next_seq;
  logic fetch_valid, redirect_pending, misalign;
  int npass = 0, ntot = 0;
  logic [31:0] m_pc, m_pt;
  logic m_pend, m_pexc, m_mis, m_started;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready), .exc_valid(exc_valid),
    .br_taken(br_taken), .br_target(br_target), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .pc(pc), .pc_next_seq(pc_next_seq), .fetch_valid(fetch_valid),
    .redirect_pending(redirect_pending), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, rdy, exc, br;
    logic [31:0] bt;
    logic jmp;
    logic [31:0] jt, epc;
    logic erp, efv, emis;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t v(logic s, logic r, logic e, logic b, logic [31:0] bt, logic j,
                             logic [31:0] jt, logic [31:0] epc, logic erp, logic efv, logic emis);
    v = '{s, r, e, b, bt, j, jt, epc, erp, efv, emis};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = RV; m_pend = 0; m_pexc = 0; m_pt = 0; m_mis = 0; m_started = 0;
  endtask

  // reference: resolve redirects by the documented priority order using plain values
  task automatic model_edge();
    logic [31:0] tgt;
    logic redir;
    if (imem_ready && !stall && m_started) begin
      redir = 1;
      if (exc_valid) tgt = EV;
      else if (m_pend && m_pexc) tgt = m_pt;
      else if (br_taken) tgt = br_target;
      else if (jmp_valid) tgt = jmp_target;
      else if (m_pend) tgt = m_pt;
      else begin redir = 0; tgt = m_pc + 4; end
      m_pc = redir ? {tgt[31:2], 2'b00} : tgt;
      m_mis = redir && tgt[1:0] != 2'b00;
      m_pend = 0;
    end else if ((exc_valid || br_taken || jmp_valid) && (exc_valid || !(m_pend && m_pexc))) begin
      m_pend = 1;
      m_pexc = exc_valid;
      m_pt = exc_valid ? EV : br_taken ? br_target : jmp_target;
    end
    m_started = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(logic s, logic r, logic e, logic b, logic [31:0] bt, logic j, logic [31:0] jt);
    stall = s; imem_ready = r; exc_valid = e; br_taken = b; br_target = bt; jmp_valid = j; jmp_target = jt;
  endtask

  task automatic check_model(string tag);
    check({tag, " pc"}, pc, m_pc);
    check({tag, " pc_next_seq"}, pc_next_seq, m_pc + 32'd4);
    check({tag, " redirect_pending"}, 32'(redirect_pending), 32'(m_pend));
    check({tag, " fetch_valid"}, 32'(fetch_valid), 32'(m_started & ~m_pend));
    check({tag, " misalign"}, 32'(misalign), 32'(m_mis));
  endtask

  initial begin
    tv.push_back(v(0,1,0,0,0,0,0,                      32'hBFC0_0000,0,1,0));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'hBFC0_0004,0,1,0));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'hBFC0_0008,0,1,0));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'hBFC0_000C,0,1,0));
    tv.push_back(v(0,1,0,1,32'h0040_0100,1,32'h0040_0200,32'h0040_0100,0,1,0));
    tv.push_back(v(1,1,0,0,0,1,32'h0040_0200,          32'h0040_0100,1,0,0));
    tv.push_back(v(1,1,0,0,0,0,0,                      32'h0040_0100,1,0,0));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'h0040_0200,0,1,0));
    tv.push_back(v(1,1,1,0,0,0,0,                      32'h0040_0200,1,0,0));
    tv.push_back(v(1,1,0,1,32'h0040_0300,0,0,          32'h0040_0200,1,0,0));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'h8000_0180,0,1,0));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'h8000_0184,0,1,0));
    tv.push_back(v(0,1,0,0,0,1,32'hFFFF_FFFC,          32'hFFFF_FFFC,0,1,0));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'h0000_0000,0,1,0));
    tv.push_back(v(0,1,0,1,32'h0040_0102,0,0,          32'h0040_0100,0,1,1));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'h0040_0104,0,1,0));
    tv.push_back(v(0,0,0,1,32'h0040_0203,0,0,          32'h0040_0104,1,0,0));
    tv.push_back(v(0,1,0,0,0,1,32'h0040_0400,          32'h0040_0400,0,1,0));
    tv.push_back(v(1,1,0,0,0,1,32'h0040_0500,          32'h0040_0400,1,0,0));
    tv.push_back(v(1,1,0,1,32'h0040_0601,0,0,          32'h0040_0400,1,0,0));
    tv.push_back(v(0,1,0,0,0,0,0,                      32'h0040_0600,0,1,1));

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset pc", pc, RV);
    check("reset redirect_pending", 32'(redirect_pending), 0);
    check("reset fetch_valid", 32'(fetch_valid), 0);
    check("reset misalign", 32'(misalign), 0);
    rst_n = 1;

    foreach (tv[i]) begin
      drive(tv[i].stall, tv[i].rdy, tv[i].exc, tv[i].br, tv[i].bt, tv[i].jmp, tv[i].jt);
      step();
      check($sformatf("vec%0d pc", i), pc, tv[i].epc);
      check($sformatf("vec%0d redirect_pending", i), 32'(redirect_pending), 32'(tv[i].erp));
      check($sformatf("vec%0d fetch_valid", i), 32'(fetch_valid), 32'(tv[i].efv));
      check($sformatf("vec%0d misalign", i), 32'(misalign), 32'(tv[i].emis));
    end

    // reset mid-stall with a pending redirect must clear immediately, without a clock edge
    drive(1, 1, 0, 0, 0, 1, 32'h0040_0700);
    step();
    check("pre-reset redirect_pending", 32'(redirect_pending), 1);
    #3 rst_n = 0;
    #1;
    check("async reset pc", pc, RV);
    check("async reset redirect_pending", 32'(redirect_pending), 0);
    check("async reset fetch_valid", 32'(fetch_valid), 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 5) == 0, $urandom);
      step();
      check_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
